// File: rtl/uart_pkg.sv
// Shared types and constants for the serial frame receiver.
//  rx_state_t : receiver FSM states
//  FRAME_BITS : line bits per frame (start + data + optional parity + stops)
//  STOP_BITS  : stop bits per frame
//  IDLE_LVL   : idle/stop level of the serial line
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit to the frame).
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop1,
      StStop2
   } rx_state_t;

   localparam int unsigned STOP_BITS = 2;

`ifdef UART_RX_PARITY_EN
   localparam int unsigned FRAME_BITS = 12;
`else
   localparam int unsigned FRAME_BITS = 11;
`endif

   localparam logic IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the serial receiver.
// Counts while en_i is high and restarts on clear_i or after each full period.
//  clk, rst_n  : clock, asynchronous active-low reset
//  en_i        : count enable (low holds the counter at zero)
//  clear_i     : restart the period from zero
//  slow_i      : 0 = period CLKS_PER_BIT, 1 = period 2*CLKS_PER_BIT
//  mid_tick_o  : counter at half period minus one
//  bit_tick_o  : counter at full period minus one
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 46880,
   parameter int unsigned CNT_W        = $clog2(2 * CLKS_PER_BIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clear_i,
   input  logic slow_i,
   output logic mid_tick_o,
   output logic bit_tick_o
);

   localparam logic [CNT_W-1:0] FastMid = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FastBit = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] SlowMid = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] SlowBit = CNT_W'(2 * CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] mid_last, bit_last;

   always_comb begin
      mid_last = slow_i ? SlowMid : FastMid;
      bit_last = slow_i ? SlowBit : FastBit;
   end

   assign mid_tick_o = en_i && (cnt_q == mid_last);
   assign bit_tick_o = en_i && (cnt_q == bit_last);

   // Largest value reached is 2*CLKS_PER_BIT-1, so the counter never wraps in a frame.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!en_i || clear_i || bit_tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// Oversampling serial frame receiver with a 1-entry valid/ready holding register.
// Frame: start(0), DATA_W data bits LSB-first, [even parity], two stop bits(1).
// Optional feature macro: UART_RX_PARITY_EN (parity bit present and checked;
// otherwise the frame has no parity slot and parity_err_o is tied low).
//  clk, rst_n   : clock, asynchronous active-low reset
//  in           : raw serial line, idle high, asynchronous to clk
//  baud_sel     : 0 = CLKS_PER_BIT per bit, 1 = 2*CLKS_PER_BIT per bit
//  data_o       : received byte, valid while valid_o is high
//  valid_o      : holding register full
//  ready_i      : consumer accepts data_o when valid_o && ready_i
//  frame_err_o  : 1-cycle pulse, a stop bit sampled low
//  parity_err_o : 1-cycle pulse, even parity mismatch
//  overrun_o    : 1-cycle pulse, good byte dropped because the holding register was full
//  busy_o       : receiver not idle
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 46880,
   parameter int unsigned DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in,
   input  logic              baud_sel,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              frame_err_o,
   output logic              parity_err_o,
   output logic              overrun_o,
   output logic              busy_o
);

   localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

   logic              sync1_q, sync2_q, line_prev_q;
   logic              line_s, start_edge;
   rx_state_t         state_q;
   logic              baud_q;
   logic [BitCntW-1:0] bit_cnt_q;
   logic [DATA_W-1:0] shift_q, data_q;
   logic              valid_q;
   logic              stop_err_q;
   logic              frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
   logic              par_err_q, parity_err_q;
`endif
   logic              tick_en, tick_clear, mid_tick, bit_tick;
   logic              frame_bad;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= IDLE_LVL;
         sync2_q     <= IDLE_LVL;
         line_prev_q <= IDLE_LVL;
      end else begin
         sync1_q     <= in;
         sync2_q     <= sync1_q;
         line_prev_q <= sync2_q;
      end
   end

   assign line_s     = sync2_q;
   // A held-low line produces no edge, so IDLE needs a high level before a new start.
   assign start_edge = (line_prev_q == IDLE_LVL) && (line_s != IDLE_LVL);

   assign tick_en    = (state_q != StIdle);
   // Re-align the period counter to mid-bit once the start bit is confirmed.
   assign tick_clear = (state_q == StStart) && mid_tick;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (tick_en),
      .clear_i    (tick_clear),
      .slow_i     (baud_q),
      .mid_tick_o (mid_tick),
      .bit_tick_o (bit_tick)
   );

   // Either stop bit low; the STOP2 sample is the live line value.
   assign frame_bad = stop_err_q || (line_s != IDLE_LVL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         baud_q       <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         stop_err_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         // Consumer handshake; a load later in this block takes precedence.
         if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            StIdle: begin
               if (start_edge) begin
                  state_q <= StStart;
                  baud_q  <= baud_sel;
               end
            end

            StStart: begin
               if (mid_tick) begin
                  if (line_s == IDLE_LVL) begin
                     state_q <= StIdle;  // glitch, not a start bit
                  end else begin
                     state_q    <= StData;
                     bit_cnt_q  <= '0;
                     stop_err_q <= 1'b0;
                  end
               end
            end

            StData: begin
               if (bit_tick) begin
                  shift_q <= {line_s, shift_q[DATA_W-1:1]};
                  if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= StParity;
`else
                     state_q <= StStop1;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (bit_tick) begin
                  par_err_q <= ^{shift_q, line_s};
                  state_q   <= StStop1;
               end
            end
`endif

            StStop1: begin
               if (bit_tick) begin
                  stop_err_q <= (line_s != IDLE_LVL);
                  state_q    <= StStop2;
               end
            end

            StStop2: begin
               if (bit_tick) begin
                  state_q <= StIdle;
                  // Resolve priority: frame > parity > overrun > load.
                  if (frame_bad) begin
                     frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (par_err_q) begin
                     parity_err_q <= 1'b1;
`endif
                  end else if (valid_q && !ready_i) begin
                     overrun_q <= 1'b1;
                  end else begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                  end
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;
   assign busy_o      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = parity_err_q;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx (CLKS_PER_BIT = 16).
module tb_uart_frame_rx;
   import uart_pkg::*;

   localparam int Cpb       = 16;
   localparam int OutGood   = 0;
   localparam int OutFrame  = 1;
   localparam int OutParity = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       line;
   logic       baud_sel;
   logic       ready;
   logic [7:0] data;
   logic       valid, ferr, perr, ovr, busy;

   always #5 clk = ~clk;

   uart_frame_rx #(
      .CLKS_PER_BIT (Cpb),
      .DATA_W       (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in           (line),
      .baud_sel     (baud_sel),
      .data_o       (data),
      .valid_o      (valid),
      .ready_i      (ready),
      .frame_err_o  (ferr),
      .parity_err_o (perr),
      .overrun_o    (ovr),
      .busy_o       (busy)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_ferr   = 0;
   int n_perr   = 0;
   int n_ovr    = 0;
   int n_vcyc   = 0;
   int rise_cyc = 0;
   int start_cyc = 0;
   logic valid_prev = 1'b0;
   logic [7:0] acc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observation at the falling edge: accepted bytes, error pulses, valid timing.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) n_vcyc++;
         if (valid && !valid_prev) rise_cyc = cyc;
         if (valid && ready) acc_q.push_back(data);
         if (ferr) n_ferr++;
         if (perr) n_perr++;
         if (ovr) n_ovr++;
      end
      valid_prev = valid;
   end

   // kind: 0 good, 1 stop1 low, 2 parity inverted, 3 stop2 low. Called #1 after posedge.
   task automatic send_frame(input logic [7:0] b, input int p, input int kind, input int nbits);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
      bits.push_back((kind == 2) ? ~(^b) : (^b));
`endif
      bits.push_back((kind == 1) ? 1'b0 : 1'b1);
      bits.push_back((kind == 3) ? 1'b0 : 1'b1);
      start_cyc = cyc;
      for (int i = 0; i < nbits && i < bits.size(); i++) begin
         line = bits[i];
         repeat (p) @(posedge clk);
         #1;
      end
      line = 1'b1;
   endtask

   // Expected outcome from the frame rules alone.
   function automatic int model_outcome(input logic [7:0] b, input int kind);
      logic stop1, stop2, par;
      stop1 = (kind != 1);
      stop2 = (kind != 3);
      par   = (kind == 2) ? ~(^b) : (^b);
      if (!stop1 || !stop2) return OutFrame;
`ifdef UART_RX_PARITY_EN
      if ((^{b, par}) != 1'b0) return OutParity;
`else
      if (par !== par) return OutParity;
`endif
      return OutGood;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; line = 1'b1; baud_sel = 1'b0; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if ({ferr, perr, ovr} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {ferr, perr, ovr}); end
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int a0, v0, f0, p0, exp_lat;
      baud_sel = 1'b0; ready = 1'b1;
      a0 = acc_q.size(); v0 = n_vcyc; f0 = n_ferr; p0 = n_perr;
      send_frame(8'hA5, Cpb, 0, 99);
      repeat (4) @(posedge clk);
      #1;
      exp_lat = 3 + Cpb / 2 + Cpb * (FRAME_BITS - 1);
      checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL a5_count: got %0d expected 1", acc_q.size() - a0); end
      else begin
         checks++; if (acc_q[$] !== 8'hA5) begin failures++; $display("FAIL a5_data: got %h expected a5", acc_q[$]); end
      end
      checks++; if (n_vcyc - v0 !== 1) begin failures++; $display("FAIL a5_valid_cycles: got %0d expected 1", n_vcyc - v0); end
      checks++; if (n_ferr - f0 + n_perr - p0 !== 0) begin failures++; $display("FAIL a5_errors: got %0d expected 0", n_ferr - f0 + n_perr - p0); end
      checks++; if (rise_cyc - start_cyc !== exp_lat) begin failures++; $display("FAIL a5_latency: got %0d expected %0d", rise_cyc - start_cyc, exp_lat); end
   endtask

   task automatic test_slow();
      int a0;
      baud_sel = 1'b1; ready = 1'b1;
      a0 = acc_q.size();
      send_frame(8'h3C, 2 * Cpb, 0, 99);
      repeat (4) @(posedge clk);
      #1;
      checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL slow_count: got %0d expected 1", acc_q.size() - a0); end
      else begin
         checks++; if (acc_q[$] !== 8'h3C) begin failures++; $display("FAIL slow_data: got %h expected 3c", acc_q[$]); end
      end
      baud_sel = 1'b0;
   endtask

   task automatic test_parity();
      int a0, p0;
      baud_sel = 1'b0; ready = 1'b1;
      a0 = acc_q.size(); p0 = n_perr;
      send_frame(8'h01, Cpb, 2, 99);
      repeat (4) @(posedge clk);
      #1;
`ifdef UART_RX_PARITY_EN
      checks++; if (n_perr - p0 !== 1) begin failures++; $display("FAIL parity_pulse: got %0d expected 1", n_perr - p0); end
      checks++; if (acc_q.size() - a0 !== 0) begin failures++; $display("FAIL parity_noload: got %0d expected 0", acc_q.size() - a0); end
`else
      checks++; if (n_perr - p0 !== 0) begin failures++; $display("FAIL parity_pulse: got %0d expected 0", n_perr - p0); end
      checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL parity_load: got %0d expected 1", acc_q.size() - a0); end
      else begin
         checks++; if (acc_q[$] !== 8'h01) begin failures++; $display("FAIL parity_data: got %h expected 01", acc_q[$]); end
      end
`endif
   endtask

   task automatic test_overrun();
      int a0, o0;
      baud_sel = 1'b0; ready = 1'b0;
      a0 = acc_q.size(); o0 = n_ovr;
      send_frame(8'h11, Cpb, 0, 99);
      send_frame(8'h22, Cpb, 0, 99);
      repeat (4) @(posedge clk);
      #1;
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b expected 1", valid); end
      checks++; if (data !== 8'h11) begin failures++; $display("FAIL ovr_held: got %h expected 11", data); end
      checks++; if (n_ovr - o0 !== 1) begin failures++; $display("FAIL ovr_pulse: got %0d expected 1", n_ovr - o0); end
      ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_drain: got %b expected 0", valid); end
      checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL ovr_accept: got %0d expected 1", acc_q.size() - a0); end
   endtask

   task automatic test_glitch();
      int a0, f0, p0;
      a0 = acc_q.size(); f0 = n_ferr; p0 = n_perr;
      line = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_on: got %b expected 1", busy); end
      line = 1'b1;
      repeat (3 * Cpb) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_off: got %b expected 0", busy); end
      checks++; if (acc_q.size() - a0 !== 0) begin failures++; $display("FAIL glitch_noload: got %0d expected 0", acc_q.size() - a0); end
      checks++; if (n_ferr - f0 + n_perr - p0 !== 0) begin failures++; $display("FAIL glitch_flags: got %0d expected 0", n_ferr - f0 + n_perr - p0); end
   endtask

   // Slow receiver, fast sender, then line held low (break).
   task automatic test_baud_mismatch();
      int a0, f0;
      baud_sel = 1'b1; ready = 1'b1;
      a0 = acc_q.size(); f0 = n_ferr;
      send_frame(8'h3C, Cpb, 0, 99);
      line = 1'b0;
      repeat (320) @(posedge clk);
      #1;
      checks++; if (n_ferr - f0 !== 1) begin failures++; $display("FAIL mismatch_ferr: got %0d expected 1", n_ferr - f0); end
      checks++; if (acc_q.size() - a0 !== 0) begin failures++; $display("FAIL mismatch_noload: got %0d expected 0", acc_q.size() - a0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_no_restart: got %b expected 0", busy); end
      line = 1'b1;
      baud_sel = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL break_valid: got %b expected 0", valid); end
   endtask

   task automatic test_reset_mid();
      int a0;
      baud_sel = 1'b0; ready = 1'b0;
      send_frame(8'h5A, Cpb, 0, 99);
      repeat (4) @(posedge clk);
      #1;
      send_frame(8'h33, Cpb, 0, 4);
      rst_n = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data: got %h expected 00", data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if ({ferr, perr, ovr} !== 3'b000) begin failures++; $display("FAIL rstmid_flags: got %b expected 000", {ferr, perr, ovr}); end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      a0 = acc_q.size();
      send_frame(8'h7E, Cpb, 0, 99);
      repeat (4) @(posedge clk);
      #1;
      checks++; if (acc_q.size() - a0 !== 1) begin failures++; $display("FAIL rstmid_count: got %0d expected 1", acc_q.size() - a0); end
      else begin
         checks++; if (acc_q[$] !== 8'h7E) begin failures++; $display("FAIL rstmid_7e: got %h expected 7e", acc_q[$]); end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int kind, p, exp_out, a0, f0, p0;
      ready = 1'b1;
      for (int n = 0; n < 12; n++) begin
         b        = 8'($urandom);
         kind     = $urandom_range(0, 3);
         baud_sel = 1'($urandom_range(0, 1));
         p        = baud_sel ? 2 * Cpb : Cpb;
         exp_out  = model_outcome(b, kind);
         a0 = acc_q.size(); f0 = n_ferr; p0 = n_perr;
         send_frame(b, p, kind, 99);
         repeat (4 + $urandom_range(0, 5)) @(posedge clk);
         #1;
         checks++; if (n_ferr - f0 !== int'(exp_out == OutFrame)) begin failures++; $display("FAIL rand_ferr[%0d]: got %0d expected %0d", n, n_ferr - f0, exp_out == OutFrame); end
         checks++; if (n_perr - p0 !== int'(exp_out == OutParity)) begin failures++; $display("FAIL rand_perr[%0d]: got %0d expected %0d", n, n_perr - p0, exp_out == OutParity); end
         checks++; if (acc_q.size() - a0 !== int'(exp_out == OutGood)) begin failures++; $display("FAIL rand_load[%0d]: got %0d expected %0d", n, acc_q.size() - a0, exp_out == OutGood); end
         if (exp_out == OutGood && acc_q.size() > a0) begin
            checks++; if (acc_q[$] !== b) begin failures++; $display("FAIL rand_data[%0d]: got %h expected %h", n, acc_q[$], b); end
         end
      end
      baud_sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slow();
      test_parity();
      test_overrun();
      test_glitch();
      test_baud_mismatch();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
